// File: rtl/bp_nonsynth_commit_matcher.sv
// Pairs in-order commit records with out-of-order register writebacks from num_rf_p
// register files. Optional same-cycle writeback bypass: BP_NONSYNTH_COMMIT_MATCHER_BYPASS_EN.
module bp_nonsynth_commit_matcher #(
  parameter int vaddr_width_p = 39,
  parameter int num_rf_p      = 2,
  parameter int commit_els_p  = 16,
  parameter int wb_els_p      = 4,
  parameter int data_width_p  = 64,
  parameter int timeout_p     = 1024
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,

  input  logic                             commit_v_i,
  input  logic [vaddr_width_p-1:0]         commit_pc_i,
  input  logic [31:0]                      commit_instr_i,
  input  logic [num_rf_p-1:0]              commit_rf_v_i,
  input  logic                             commit_trap_i,
  input  logic                             commit_debug_i,
  input  logic [63:0]                      commit_cause_i,

  input  logic [num_rf_p-1:0]              wb_v_i,
  input  logic [num_rf_p*5-1:0]            wb_addr_i,
  input  logic [num_rf_p*data_width_p-1:0] wb_data_i,

  output logic                             rec_v_o,
  input  logic                             rec_yumi_i,
  output logic [vaddr_width_p-1:0]         rec_pc_o,
  output logic [31:0]                      rec_instr_o,
  output logic                             rec_trap_o,
  output logic                             rec_debug_o,
  output logic [63:0]                      rec_cause_o,
  output logic [num_rf_p-1:0]              rec_rf_v_o,
  output logic [data_width_p-1:0]          rec_wdata_o,

  input  logic [31:0]                      instr_cap_i,
  output logic [31:0]                      instr_cnt_o,
  output logic                             finish_o,
  output logic                             commit_full_o,
  output logic                             err_overflow_o,
  output logic                             err_timeout_o
);

  localparam int cq_ptr_w = $clog2(commit_els_p);
  localparam int wb_ptr_w = $clog2(wb_els_p);
  localparam int ch_w     = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;

  localparam logic [cq_ptr_w:0]   cq_one     = (cq_ptr_w+1)'(1);
  localparam logic [wb_ptr_w:0]   wb_one     = (wb_ptr_w+1)'(1);
  localparam logic [num_rf_p-1:0] rf_one     = num_rf_p'(1);
  localparam logic [31:0]         timeout_lp = 32'(timeout_p);
  localparam logic                wd_en      = (timeout_p != 0);

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [31:0]              instr;
    logic [num_rf_p-1:0]      rf_v;
    logic                     trap;
    logic                     debug;
    logic [63:0]              cause;
  } commit_s;

  // Commit queue: pointers carry one extra wrap bit to tell full from empty.
  commit_s           cq_mem [commit_els_p];
  logic [cq_ptr_w:0] cq_wptr, cq_rptr;
  logic              cq_empty, cq_full, cq_push, cq_pop, commit_drop;
  commit_s           cq_head, cq_entry;

  logic [data_width_p-1:0] wb_mem  [num_rf_p][32][wb_els_p];
  logic [wb_ptr_w:0]       wb_wptr [num_rf_p][32];
  logic [wb_ptr_w:0]       wb_rptr [num_rf_p][32];
  logic [4:0]              wb_addr [num_rf_p];
  logic [data_width_p-1:0] wb_data [num_rf_p];
  logic [num_rf_p-1:0]     wb_push, wb_drop;

  logic [ch_w-1:0]         head_ch;
  logic [4:0]              head_rd;
  logic                    head_needs_wb, head_fifo_empty, bypass_hit, wb_pop;
  logic [data_width_p-1:0] head_fifo_data;
  logic                    finish_r;
  logic [31:0]             wd_cnt;

  always_comb begin
    cq_empty = (cq_wptr == cq_rptr);
    cq_full  = (cq_wptr[cq_ptr_w] != cq_rptr[cq_ptr_w])
            && (cq_wptr[cq_ptr_w-1:0] == cq_rptr[cq_ptr_w-1:0]);
    cq_head  = cq_mem[cq_rptr[cq_ptr_w-1:0]];
  end

  always_comb begin
    for (int c = 0; c < num_rf_p; c++) begin
      wb_addr[c] = wb_addr_i[c*5 +: 5];
      wb_data[c] = wb_data_i[c*data_width_p +: data_width_p];
    end
  end

  // Head decode: rf_v is already one-hot (or zero) from enqueue.
  always_comb begin
    head_ch = '0;
    for (int c = num_rf_p-1; c >= 0; c--) begin
      if (cq_head.rf_v[c]) head_ch = ch_w'(c);
    end
    head_rd         = cq_head.instr[11:7];
    head_needs_wb   = !cq_empty && (cq_head.rf_v != '0);
    head_fifo_empty = (wb_wptr[head_ch][head_rd] == wb_rptr[head_ch][head_rd]);
    head_fifo_data  = wb_mem[head_ch][head_rd][wb_rptr[head_ch][head_rd][wb_ptr_w-1:0]];
  end

`ifdef BP_NONSYNTH_COMMIT_MATCHER_BYPASS_EN
  assign bypass_hit = head_needs_wb && head_fifo_empty && wb_v_i[head_ch]
                   && (wb_addr[head_ch] == head_rd);
`else
  assign bypass_hit = 1'b0;
`endif

  assign rec_v_o     = !cq_empty && (!head_needs_wb || !head_fifo_empty || bypass_hit);
  assign rec_pc_o    = cq_head.pc;
  assign rec_instr_o = cq_head.instr;
  assign rec_trap_o  = cq_head.trap;
  assign rec_debug_o = cq_head.debug;
  assign rec_cause_o = cq_head.cause;
  assign rec_rf_v_o  = cq_head.rf_v;
  assign rec_wdata_o = !head_needs_wb ? '0
                     : bypass_hit     ? wb_data[head_ch]
                     :                  head_fifo_data;

  assign cq_pop = rec_yumi_i && rec_v_o;
  assign wb_pop = cq_pop && head_needs_wb && !bypass_hit;

  always_comb begin
    cq_entry.pc    = commit_pc_i;
    cq_entry.instr = commit_instr_i;
    cq_entry.rf_v  = commit_trap_i ? '0 : (commit_rf_v_i & (~commit_rf_v_i + rf_one));
    cq_entry.trap  = commit_trap_i;
    cq_entry.debug = commit_debug_i;
    cq_entry.cause = commit_cause_i;
    cq_push        = commit_v_i && (!cq_full || cq_pop);
    commit_drop    = commit_v_i && !cq_push;
  end

  // A bypassed write is consumed by the retiring record; a pop of the same FIFO frees a slot.
  always_comb begin
    wb_push = '0;
    wb_drop = '0;
    for (int c = 0; c < num_rf_p; c++) begin
      if (wb_v_i[c] && !(bypass_hit && cq_pop && (head_ch == ch_w'(c)))) begin
        if (!((wb_wptr[c][wb_addr[c]][wb_ptr_w] != wb_rptr[c][wb_addr[c]][wb_ptr_w])
              && (wb_wptr[c][wb_addr[c]][wb_ptr_w-1:0] == wb_rptr[c][wb_addr[c]][wb_ptr_w-1:0]))
            || (wb_pop && (head_ch == ch_w'(c)) && (head_rd == wb_addr[c])))
          wb_push[c] = 1'b1;
        else
          wb_drop[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cq_wptr <= '0;
      cq_rptr <= '0;
    end else begin
      if (cq_push) cq_wptr <= cq_wptr + cq_one;
      if (cq_pop)  cq_rptr <= cq_rptr + cq_one;
    end
  end

  // NOTE: storage arrays carry no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (cq_push) cq_mem[cq_wptr[cq_ptr_w-1:0]] <= cq_entry;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_rf_p; c++) begin
        for (int r = 0; r < 32; r++) begin
          wb_wptr[c][r] <= '0;
          wb_rptr[c][r] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < num_rf_p; c++) begin
        if (wb_push[c]) wb_wptr[c][wb_addr[c]] <= wb_wptr[c][wb_addr[c]] + wb_one;
      end
      if (wb_pop) wb_rptr[head_ch][head_rd] <= wb_rptr[head_ch][head_rd] + wb_one;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < num_rf_p; c++) begin
      if (wb_push[c]) wb_mem[c][wb_addr[c]][wb_wptr[c][wb_addr[c]][wb_ptr_w-1:0]] <= wb_data[c];
    end
  end

  assign commit_full_o = cq_full;
  assign finish_o      = finish_r || ((instr_cap_i != '0) && (instr_cnt_o == instr_cap_i));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      instr_cnt_o    <= '0;
      finish_r       <= 1'b0;
      err_overflow_o <= 1'b0;
      err_timeout_o  <= 1'b0;
      wd_cnt         <= '0;
    end else begin
      if (cq_pop && !cq_head.trap && !cq_head.debug && (instr_cnt_o != '1))
        instr_cnt_o <= instr_cnt_o + 32'd1;
      finish_r <= finish_o;
      if (commit_drop || (wb_drop != '0)) err_overflow_o <= 1'b1;
      // Watchdog holds (neither counts nor clears) while a ready record waits for the consumer.
      if (cq_pop || cq_empty) begin
        wd_cnt <= '0;
      end else if (wd_en && !rec_v_o && (wd_cnt != timeout_lp)) begin
        wd_cnt <= wd_cnt + 32'd1;
        if (wd_cnt + 32'd1 == timeout_lp) err_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_commit_matcher.sv
// Scoreboard bench for bp_nonsynth_commit_matcher: directed scenarios plus randomized traffic
// checked against a queue-based model of commit order and per-register writeback order.
module tb_bp_nonsynth_commit_matcher;
  localparam int VA = 39, NRF = 2, CE = 16, WE = 4, DW = 64, TO = 8;

  logic            clk_i, reset_n_i;
  logic            commit_v_i, commit_trap_i, commit_debug_i;
  logic [VA-1:0]   commit_pc_i;
  logic [31:0]     commit_instr_i;
  logic [NRF-1:0]  commit_rf_v_i;
  logic [63:0]     commit_cause_i;
  logic [NRF-1:0]  wb_v_i;
  logic [NRF*5-1:0]  wb_addr_i;
  logic [NRF*DW-1:0] wb_data_i;
  logic            rec_v_o, rec_yumi_i, rec_trap_o, rec_debug_o;
  logic [VA-1:0]   rec_pc_o;
  logic [31:0]     rec_instr_o;
  logic [63:0]     rec_cause_o;
  logic [NRF-1:0]  rec_rf_v_o;
  logic [DW-1:0]   rec_wdata_o;
  logic [31:0]     instr_cap_i, instr_cnt_o;
  logic            finish_o, commit_full_o, err_overflow_o, err_timeout_o;

  bp_nonsynth_commit_matcher #(
    .vaddr_width_p(VA), .num_rf_p(NRF), .commit_els_p(CE),
    .wb_els_p(WE), .data_width_p(DW), .timeout_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
    .commit_rf_v_i(commit_rf_v_i), .commit_trap_i(commit_trap_i),
    .commit_debug_i(commit_debug_i), .commit_cause_i(commit_cause_i),
    .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rec_v_o(rec_v_o), .rec_yumi_i(rec_yumi_i), .rec_pc_o(rec_pc_o),
    .rec_instr_o(rec_instr_o), .rec_trap_o(rec_trap_o), .rec_debug_o(rec_debug_o),
    .rec_cause_o(rec_cause_o), .rec_rf_v_o(rec_rf_v_o), .rec_wdata_o(rec_wdata_o),
    .instr_cap_i(instr_cap_i), .instr_cnt_o(instr_cnt_o), .finish_o(finish_o),
    .commit_full_o(commit_full_o), .err_overflow_o(err_overflow_o),
    .err_timeout_o(err_timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [VA-1:0] pc;
    logic [31:0]   instr;
    logic [1:0]    rf;
    logic          trap;
    logic          dbg;
    logic [63:0]   cause;
  } exp_t;
  typedef struct { int c; int r; } pend_t;

  exp_t        exp_q[$];
  logic [63:0] wbq [NRF][32][$];
  pend_t       pend_q[$];
  int checks = 0, errors = 0, model_cnt = 0, retired = 0, yumi_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted record is popped from the scoreboard and compared.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    logic [63:0] d;
    int c, r;
    if (reset_n_i && rec_v_o && rec_yumi_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_record: got pc 0x%0h, expected no record", rec_pc_o);
      end else begin
        e = exp_q.pop_front();
        d = '0;
        if (e.rf != 2'b00) begin
          c = e.rf[0] ? 0 : 1;
          r = int'(e.instr[11:7]);
          if (wbq[c][r].size() == 0) begin
            checks++; errors++;
            $display("FAIL model_no_wb: got record for ch%0d x%0d, expected pending wb", c, r);
          end else d = wbq[c][r].pop_front();
        end
        check("rec_pc", 64'(rec_pc_o), 64'(e.pc));
        check("rec_instr", 64'(rec_instr_o), 64'(e.instr));
        check("rec_trap", 64'(rec_trap_o), 64'(e.trap));
        check("rec_debug", 64'(rec_debug_o), 64'(e.dbg));
        check("rec_cause", rec_cause_o, e.cause);
        check("rec_rf_v", 64'(rec_rf_v_o), 64'(e.rf));
        check("rec_wdata", rec_wdata_o, d);
        if (!e.trap && !e.dbg) model_cnt++;
        retired++;
      end
    end
  end

  task automatic set_commit(input logic [VA-1:0] pc, input logic [31:0] instr,
                            input logic [1:0] rf, input logic trap, input logic dbg,
                            input logic [63:0] cause);
    commit_v_i = 1'b1; commit_pc_i = pc; commit_instr_i = instr; commit_rf_v_i = rf;
    commit_trap_i = trap; commit_debug_i = dbg; commit_cause_i = cause;
  endtask

  task automatic set_wb(input int c, input logic [4:0] addr, input logic [63:0] data);
    wb_v_i[c] = 1'b1;
    wb_addr_i[c*5 +: 5] = addr;
    wb_data_i[c*DW +: DW] = data;
  endtask

  // Record driven stimulus in the model, pick yumi, then advance one clock.
  task automatic issue();
    exp_t e;
    if (commit_v_i && exp_q.size() < CE) begin
      e.pc = commit_pc_i; e.instr = commit_instr_i; e.trap = commit_trap_i;
      e.dbg = commit_debug_i; e.cause = commit_cause_i;
      e.rf = commit_trap_i ? 2'b00 : commit_rf_v_i[0] ? 2'b01 : commit_rf_v_i[1] ? 2'b10 : 2'b00;
      exp_q.push_back(e);
      if (e.rf != 2'b00) pend_q.push_back('{e.rf[0] ? 0 : 1, int'(e.instr[11:7])});
    end
    for (int c = 0; c < NRF; c++)
      if (wb_v_i[c]) wbq[c][int'(wb_addr_i[c*5 +: 5])].push_back(wb_data_i[c*DW +: DW]);
    #1;
    case (yumi_mode)
      1:       rec_yumi_i = rec_v_o && ($urandom_range(0, 3) != 0);
      2:       rec_yumi_i = rec_v_o;
      default: rec_yumi_i = 1'b0;
    endcase
    @(posedge clk_i); #1;
    commit_v_i = 1'b0; wb_v_i = '0; rec_yumi_i = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete(); pend_q.delete(); model_cnt = 0;
    for (int c = 0; c < NRF; c++) for (int r = 0; r < 32; r++) wbq[c][r].delete();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    yumi_mode = 2;
    while (exp_q.size() > 0 && n < max_cycles) begin issue(); n++; end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {56'd0, rec_v_o, commit_full_o, finish_o, err_overflow_o, err_timeout_o, 3'd0},
          64'd0);
    check({name, "_cnt"}, 64'(instr_cnt_o), 64'd0);
  endtask

  initial begin : stimulus
    int r0, idx, rd;
    logic [31:0] instr;
    reset_n_i = 1'b0; commit_v_i = 1'b0; commit_pc_i = '0; commit_instr_i = '0;
    commit_rf_v_i = '0; commit_trap_i = 1'b0; commit_debug_i = 1'b0; commit_cause_i = '0;
    wb_v_i = '0; wb_addr_i = '0; wb_data_i = '0; rec_yumi_i = 1'b0; instr_cap_i = '0;

    do_reset();
    check_idle_outputs("reset_state");

    // Single addi x1 with writeback two cycles after commit.
    yumi_mode = 0;
    set_commit(39'h80000000, 32'h00500093, 2'b01, 1'b0, 1'b0, 64'd0); issue();
    issue();
    check("addi_wait_rec_v", 64'(rec_v_o), 64'd0);
    set_wb(0, 5'd1, 64'd5); issue();
    check("addi_rec_v", 64'(rec_v_o), 64'd1);
    check("addi_wdata", rec_wdata_o, 64'd5);
    drain("addi_drain", 10);
    check("addi_cnt", 64'(instr_cnt_o), 64'd1);

    // Two x3 writers on different channels, writebacks in reverse order.
    do_reset();
    set_commit(39'h80000004, 32'h000001b3, 2'b01, 1'b0, 1'b0, 64'd0); issue();
    set_commit(39'h80000008, 32'h000001d3, 2'b10, 1'b0, 1'b0, 64'd0); issue();
    set_wb(1, 5'd3, 64'hAA); issue();
    check("x3_head_wait", 64'(rec_v_o), 64'd0);
    set_wb(0, 5'd3, 64'hBB); issue();
    drain("x3_drain", 10);
    check("x3_cnt", 64'(instr_cnt_o), 64'd2);

    // Commit queue overflow.
    do_reset();
    yumi_mode = 0;
    for (int i = 0; i < 16; i++) begin
      set_commit(39'h1000 + 39'(4*i), 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    end
    check("full_at_16", 64'(commit_full_o), 64'd1);
    check("no_ovf_at_16", 64'(err_overflow_o), 64'd0);
    set_commit(39'h2000, 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    check("ovf_on_17", 64'(err_overflow_o), 64'd1);
    r0 = retired;
    drain("ovf_drain", 40);
    check("ovf_drain_count", 64'(retired - r0), 64'd16);
    check("ovf_not_full", 64'(commit_full_o), 64'd0);

    // Trap does not count; cap of 3 raises sticky finish.
    do_reset();
    instr_cap_i = 32'd3; yumi_mode = 2;
    set_commit(39'h3000, 32'h00000073, 2'b01, 1'b1, 1'b0, 64'h2); issue();
    set_commit(39'h3004, 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    set_commit(39'h3008, 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    issue();
    check("cap_cnt_2", 64'(instr_cnt_o), 64'd2);
    check("cap_finish_early", 64'(finish_o), 64'd0);
    set_commit(39'h300c, 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    issue();
    check("cap_cnt_3", 64'(instr_cnt_o), 64'd3);
    check("cap_finish", 64'(finish_o), 64'd1);
    set_commit(39'h3010, 32'h00000013, 2'b00, 1'b0, 1'b0, 64'd0); issue();
    issue();
    check("cap_cnt_4", 64'(instr_cnt_o), 64'd4);
    check("cap_finish_sticky", 64'(finish_o), 64'd1);

    // Watchdog on a head whose writeback never arrives, then asynchronous reset.
    yumi_mode = 0;
    set_commit(39'h4000, 32'h00000293, 2'b01, 1'b0, 1'b0, 64'd0); issue();
    for (int i = 1; i < TO; i++) issue();
    check("wd_before_limit", 64'(err_timeout_o), 64'd0);
    check("wd_stalled", 64'(rec_v_o), 64'd0);
    issue();
    check("wd_at_limit", 64'(err_timeout_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    instr_cap_i = '0;
    do_reset();

`ifdef BP_NONSYNTH_COMMIT_MATCHER_BYPASS_EN
    // Same-cycle bypass of a writeback into an empty FIFO.
    yumi_mode = 0;
    set_commit(39'h5000, 32'h00000113, 2'b01, 1'b0, 1'b0, 64'd0); issue();
    set_wb(0, 5'd2, 64'd7);
    wbq[0][2].push_back(64'd7);
    #1;
    check("byp_rec_v", 64'(rec_v_o), 64'd1);
    check("byp_wdata", rec_wdata_o, 64'd7);
    rec_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    wb_v_i = '0; rec_yumi_i = 1'b0;
    set_commit(39'h5004, 32'h00000113, 2'b01, 1'b0, 1'b0, 64'd0); issue();
    issue();
    check("byp_fifo_empty", 64'(rec_v_o), 64'd0);
    do_reset();
`endif

    // Randomized traffic: writebacks arrive in any order across registers and channels.
    yumi_mode = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < NRF; c++) begin
        idx = -1;
        for (int i = 0; i < pend_q.size(); i++)
          if (pend_q[i].c == c) begin idx = i; break; end
        if (idx >= 0 && $urandom_range(0, 7) != 0 && wbq[c][pend_q[idx].r].size() < WE) begin
          set_wb(c, 5'(pend_q[idx].r), {$urandom, $urandom});
          pend_q.delete(idx);
        end
      end
      if ($urandom_range(0, 1) == 1 && exp_q.size() < CE) begin
        rd = $urandom_range(0, 3);
        instr = $urandom;
        instr[11:7] = 5'(rd);
        set_commit({7'd0, $urandom}, instr, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, {$urandom, $urandom});
      end
      issue();
    end
    yumi_mode = 2;
    for (int cyc = 0; cyc < 400 && (exp_q.size() > 0 || pend_q.size() > 0); cyc++) begin
      for (int c = 0; c < NRF; c++) begin
        idx = -1;
        for (int i = 0; i < pend_q.size(); i++)
          if (pend_q[i].c == c) begin idx = i; break; end
        if (idx >= 0 && wbq[c][pend_q[idx].r].size() < WE) begin
          set_wb(c, 5'(pend_q[idx].r), {$urandom, $urandom});
          pend_q.delete(idx);
        end
      end
      issue();
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_no_ovf", 64'(err_overflow_o), 64'd0);
    check("rand_no_timeout", 64'(err_timeout_o), 64'd0);
    check("rand_cnt", 64'(instr_cnt_o), 64'(model_cnt));
    check("rand_no_finish", 64'(finish_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : time_limit
    #500000;
    $display("FAIL time_limit: simulation still running at %0t, expected completion", $time);
    $fatal(1, "time limit");
  end

endmodule
